// File: rtl/dcache_wb_if.sv
// Pipeline and line-wide memory bus signals of the data cache, bundled as one interface.
// master = the cache itself (serves the pipeline, masters the memory bus).
// slave  = the surrounding pipeline/memory environment.
interface dcache_wb_if #(
  parameter int DATA_WIDTH = 32
);
  // pipeline side
  logic                      rd_en;
  logic                      wr_en;
  logic [31:0]               addr;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   byte_en;
  logic [DATA_WIDTH-1:0]     rdata;
  logic                      cache_busy;
  // memory side
  logic                      mem_req;
  logic                      mem_we;
  logic [31:0]               mem_addr;
  logic [4*DATA_WIDTH-1:0]   mem_wdata;
  logic [4*DATA_WIDTH-1:0]   mem_rdata;
  logic                      mem_ready;

  modport master (
    input  rd_en, wr_en, addr, wdata, byte_en, mem_rdata, mem_ready,
    output rdata, cache_busy, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output rd_en, wr_en, addr, wdata, byte_en, mem_rdata, mem_ready,
    input  rdata, cache_busy, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate data cache with a 4-word line.
// Hits complete in the same cycle; a miss costs writeback (if dirty) plus refill.
// cache_busy stalls the pipeline on a miss; each memory phase waits on mem_ready.
module dcache_wb #(
  parameter int DATA_WIDTH = 32,
  parameter int SETS       = 256
) (
  input  logic         clk,
  input  logic         rst,
  dcache_wb_if.master  bus
);
  localparam int LINE_W = 4 * DATA_WIDTH;
  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 32 - 4 - IDX_W;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] REFILL    = 2'd2;

  logic [1:0]        state;
  logic [SETS-1:0]   validQ;
  logic [SETS-1:0]   dirtyQ;
  logic [TAG_W-1:0]  tagQ  [SETS];
  logic [LINE_W-1:0] dataQ [SETS];

  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      reqTag;
  logic [1:0]            wordSel;
  logic                  req;
  logic                  hit;
  logic                  storeHit;
  logic                  refillDone;
  logic [LINE_W-1:0]     curLine;
  logic [DATA_WIDTH-1:0] curWord;
  logic [DATA_WIDTH-1:0] mergedWord;
  logic [LINE_W-1:0]     storeLine;
  logic                  unusedAddrLsb;

  assign idx        = bus.addr[4 +: IDX_W];
  assign reqTag     = bus.addr[31 -: TAG_W];
  assign wordSel    = bus.addr[3:2];
  // Byte position within the word is already carried by byte_en.
  assign unusedAddrLsb = ^bus.addr[1:0];

  assign req        = bus.rd_en | bus.wr_en;
  assign hit        = req & validQ[idx] & (tagQ[idx] == reqTag);
  // Simultaneous rd_en/wr_en is treated as a store.
  assign storeHit   = (state == IDLE) & hit & bus.wr_en;
  assign refillDone = (state == REFILL) & bus.mem_ready;
  assign curLine    = dataQ[idx];
  assign curWord    = curLine[wordSel*DATA_WIDTH +: DATA_WIDTH];

  // Merge the enabled store bytes into the addressed word and rebuild the line.
  always_comb begin
    mergedWord = curWord;
    for (int b = 0; b < BYTES; b++) begin
      if (bus.byte_en[b]) mergedWord[b*8 +: 8] = bus.wdata[b*8 +: 8];
    end
    storeLine = curLine;
    storeLine[wordSel*DATA_WIDTH +: DATA_WIDTH] = mergedWord;
  end

  // Pipeline responses and memory requests decoded from the current state.
  always_comb begin
    bus.rdata      = '0;
    bus.cache_busy = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    case (state)
      IDLE: begin
        bus.cache_busy = req & ~hit;
        if (hit & ~bus.wr_en) bus.rdata = curWord;
      end
      WRITEBACK: begin
        bus.cache_busy = 1'b1;
        bus.mem_req    = 1'b1;
        bus.mem_we     = 1'b1;
        bus.mem_addr   = {tagQ[idx], idx, 4'b0000};
        bus.mem_wdata  = curLine;
      end
      REFILL: begin
        bus.cache_busy = 1'b1;
        bus.mem_req    = 1'b1;
        bus.mem_addr   = {reqTag, idx, 4'b0000};
      end
      default: ;
    endcase
  end

  // Data/tag arrays: store-hit merge or full-line refill; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (storeHit) begin
        dataQ[idx] <= storeLine;
      end else if (refillDone) begin
        dataQ[idx] <= bus.mem_rdata;
        tagQ[idx]  <= reqTag;
      end
    end
  end

  // Miss sequencer plus valid/dirty bookkeeping; reset aborts any memory phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      validQ <= '0;
      dirtyQ <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (storeHit) begin
            dirtyQ[idx] <= 1'b1;
          end else if (req && !hit) begin
            state <= (validQ[idx] && dirtyQ[idx]) ? WRITEBACK : REFILL;
          end
        end
        WRITEBACK: begin
          if (bus.mem_ready) state <= REFILL;
        end
        REFILL: begin
          if (bus.mem_ready) begin
            validQ[idx] <= 1'b1;
            dirtyQ[idx] <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_wb.sv
// Directed bench for dcache_wb: misses, store hits, dirty/clean eviction, reset abort.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_dcache_wb;
  logic clk;
  logic rst;
  int   totalCnt;
  int   badCnt;

  dcache_wb_if #(.DATA_WIDTH(32)) bus ();

  dcache_wb #(.DATA_WIDTH(32), .SETS(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] LINE1 = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
  localparam logic [127:0] VICT1 = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBB55_BBBB, 32'hAAAA_AAAA};
  localparam logic [127:0] LINE2 = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
  localparam logic [127:0] LINE3 = {32'h8888_8888, 32'h7777_7777, 32'h6666_6666, 32'h5A5A_5A5A};
  localparam logic [127:0] LINE4 = {32'hF0F0_F0F0, 32'hE0E0_E0E0, 32'hD0D0_D0D0, 32'hC0C0_C0C0};

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    totalCnt++;
    if (got !== exp) begin
      badCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd);
    bus.rd_en   = rd;
    bus.wr_en   = wr;
    bus.addr    = a;
    bus.byte_en = be;
    bus.wdata   = wd;
  endtask

  // Called at the start of the first cycle in which mem_req should be high.
  // Holds mem_ready low for nCycles-1 cycles, then completes with rline.
  task automatic memTxn(input string tag, input logic [31:0] expAddr, input logic expWe,
                        input logic chkWdata, input logic [127:0] expWdata,
                        input logic [127:0] rline, input int nCycles);
    for (int c = 0; c < nCycles; c++) begin
      if (c == nCycles - 1) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rline;
      end
      @(negedge clk);
      check({tag, " mem_req"},  128'(bus.mem_req), 128'(1'b1));
      check({tag, " mem_we"},   128'(bus.mem_we), 128'(expWe));
      check({tag, " mem_addr"}, 128'(bus.mem_addr), 128'(expAddr));
      check({tag, " busy"},     128'(bus.cache_busy), 128'(1'b1));
      if (chkWdata) check({tag, " mem_wdata"}, bus.mem_wdata, expWdata);
      tick();
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
    end
  endtask

  // One zero-stall access: check busy/mem_req low and the returned word.
  task automatic hitCycle(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] wd, input logic [31:0] expRd);
    setReq(rd, wr, a, be, wd);
    @(negedge clk);
    check({tag, " busy"},    128'(bus.cache_busy), 128'(1'b0));
    check({tag, " mem_req"}, 128'(bus.mem_req), 128'(1'b0));
    check({tag, " rdata"},   128'(bus.rdata), 128'(expRd));
    tick();
  endtask

  initial begin
    totalCnt = 0;
    badCnt   = 0;
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    setReq(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // reset state
    @(negedge clk);
    check("rst mem_req",   128'(bus.mem_req), 128'(1'b0));
    check("rst mem_we",    128'(bus.mem_we), 128'(1'b0));
    check("rst mem_addr",  128'(bus.mem_addr), 128'(32'h0));
    check("rst mem_wdata", bus.mem_wdata, 128'h0);
    check("rst rdata",     128'(bus.rdata), 128'(32'h0));
    check("rst busy",      128'(bus.cache_busy), 128'(1'b0));
    tick();

    // 1: clean read miss, ready in third cycle of mem_req -> 4 busy cycles
    setReq(1'b1, 1'b0, 32'h0000_0104, 4'h0, 32'h0);
    @(negedge clk);
    check("t1 miss busy",  128'(bus.cache_busy), 128'(1'b1));
    check("t1 miss noreq", 128'(bus.mem_req), 128'(1'b0));
    tick();
    memTxn("t1 refill", 32'h0000_0100, 1'b0, 1'b0, 128'h0, LINE1, 3);
    hitCycle("t1 hit", 1'b1, 1'b0, 32'h0000_0104, 4'h0, 32'h0, 32'hBBBB_BBBB);

    // 2: byte store hit, then read back the merged word
    hitCycle("t2 store", 1'b0, 1'b1, 32'h0000_0104, 4'b0100, 32'h0055_0000, 32'h0);
    hitCycle("t2 load",  1'b1, 1'b0, 32'h0000_0104, 4'h0, 32'h0, 32'hBB55_BBBB);

    // 3: dirty eviction at index 0x10, writeback then refill with ready at once
    setReq(1'b1, 1'b0, 32'h0000_1104, 4'h0, 32'h0);
    @(negedge clk);
    check("t3 miss busy", 128'(bus.cache_busy), 128'(1'b1));
    tick();
    memTxn("t3 wb",     32'h0000_0100, 1'b1, 1'b1, VICT1, 128'h0, 2);
    memTxn("t3 refill", 32'h0000_1100, 1'b0, 1'b0, 128'h0, LINE2, 1);
    hitCycle("t3 hit", 1'b1, 1'b0, 32'h0000_1104, 4'h0, 32'h0, 32'h2222_2222);

    // 4: clean eviction goes straight to refill (minimum 2-cycle stall)
    setReq(1'b1, 1'b0, 32'h0000_2100, 4'h0, 32'h0);
    @(negedge clk);
    check("t4 miss busy", 128'(bus.cache_busy), 128'(1'b1));
    tick();
    memTxn("t4 refill", 32'h0000_2100, 1'b0, 1'b0, 128'h0, LINE3, 1);
    hitCycle("t4 hit", 1'b1, 1'b0, 32'h0000_2100, 4'h0, 32'h0, 32'h5A5A_5A5A);

    // 5: reset while in refill aborts; previously cached line is gone
    setReq(1'b1, 1'b0, 32'h0000_3104, 4'h0, 32'h0);
    @(negedge clk);
    check("t5 miss busy", 128'(bus.cache_busy), 128'(1'b1));
    tick();
    @(negedge clk);
    check("t5 in refill", 128'(bus.mem_req), 128'(1'b1));
    tick();
    rst = 1'b1;
    bus.rd_en = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t5 post mem_req", 128'(bus.mem_req), 128'(1'b0));
    check("t5 post busy",    128'(bus.cache_busy), 128'(1'b0));
    tick();
    setReq(1'b1, 1'b0, 32'h0000_0104, 4'h0, 32'h0);
    @(negedge clk);
    check("t5 reread busy",  128'(bus.cache_busy), 128'(1'b1));
    check("t5 reread rdata", 128'(bus.rdata), 128'(32'h0));
    tick();
    memTxn("t5 refill", 32'h0000_0100, 1'b0, 1'b0, 128'h0, LINE1, 2);
    hitCycle("t5 hit", 1'b1, 1'b0, 32'h0000_0104, 4'h0, 32'h0, 32'hBBBB_BBBB);

    // 6: fill index 0x20, then back-to-back mixed hits with zero stall
    setReq(1'b1, 1'b0, 32'h0000_0208, 4'h0, 32'h0);
    @(negedge clk);
    check("t6 miss busy", 128'(bus.cache_busy), 128'(1'b1));
    tick();
    memTxn("t6 refill", 32'h0000_0200, 1'b0, 1'b0, 128'h0, LINE4, 1);
    hitCycle("t6 a", 1'b1, 1'b0, 32'h0000_0104, 4'h0, 32'h0, 32'hBBBB_BBBB);
    hitCycle("t6 b", 1'b1, 1'b0, 32'h0000_0208, 4'h0, 32'h0, 32'hE0E0_E0E0);
    hitCycle("t6 c rw", 1'b1, 1'b1, 32'h0000_020C, 4'b1111, 32'h1234_5678, 32'h0);
    hitCycle("t6 d", 1'b1, 1'b0, 32'h0000_020C, 4'h0, 32'h0, 32'h1234_5678);
    hitCycle("t6 e", 1'b0, 1'b1, 32'h0000_0100, 4'b0001, 32'h0000_00EE, 32'h0);
    hitCycle("t6 f", 1'b1, 1'b0, 32'h0000_0100, 4'h0, 32'h0, 32'hAAAA_AAEE);
    hitCycle("t6 idle", 1'b0, 1'b0, 32'h0000_0100, 4'h0, 32'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
    $finish;
  end
endmodule

// File: doc/dcache_wb.md
# dcache_wb

Direct-mapped, write-back, write-allocate data cache sitting directly downstream of the Memory-stage load/store logic and upstream of main memory. It serves word and byte-masked accesses from the pipeline in the same cycle on a hit. On a miss it raises `cache_busy` so the hazard unit stalls the pipeline. It then runs a writeback/refill sequence over a 128-bit line-wide memory handshake.

## Interface
**Parameters**
- `DATA_WIDTH`, default 32: pipeline word width.
- `SETS`, default 256: number of lines, a power of two.
- Line size is fixed at 4 words (16 bytes).
- Derived fields: `offset` = `addr[3:0]`, `index` = `addr[11:4]`, `tag` = `addr[31:12]` (20 bits).

**Ports**
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `rd_en`, in, 1: load request this cycle.
- `wr_en`, in, 1: store request this cycle.
- `addr`, in, 32: byte address from `ALUResultM`.
- `wdata`, in, 32: store data, already lane-aligned.
- `byte_en`, in, 4: store byte-lane mask (1111 word, 0011 half, 0001 byte, shifted by `addr[1:0]`).
- `rdata`, out, 32: full load word on a hit; MEMtop extracts sub-words.
- `cache_busy`, out, 1: request not yet satisfied; stall the pipeline.
- `mem_req`, out, 1: memory transaction request.
- `mem_we`, out, 1: 1 = line write (writeback), 0 = line read (refill).
- `mem_addr`, out, 32: line-aligned address (`[3:0]` = 0).
- `mem_wdata`, out, 128: victim line; word 0 in bits [31:0].
- `mem_rdata`, in, 128: refill line, same word ordering.
- `mem_ready`, in, 1: memory completes the current transaction this cycle.

## Operation
**Storage and request rules**
- Per line: `valid`, `dirty`, 20-bit tag, 128-bit data.
- `req` = `rd_en | wr_en`. If both are asserted, treat the request as a store.
- `hit` = `req & valid[index] & (tag[index] == addr tag)`.

**States**
- **IDLE**
  - Hit load: `rdata` = selected word combinationally; `cache_busy` = 0.
  - Hit store: at the edge, update the enabled bytes of the selected word and set `dirty`; `cache_busy` = 0.
  - Miss: `cache_busy` = 1 combinationally. Next state is WRITEBACK if the victim is `valid & dirty`, else REFILL.
  - No request: `cache_busy` = 0 and no state change.
- **WRITEBACK**
  - Outputs: `mem_req` = 1, `mem_we` = 1, `mem_addr` = {victim tag, index, 4'b0}, `mem_wdata` = victim line.
  - Hold all outputs stable until `mem_ready`, then go to REFILL.
  - `cache_busy` = 1.
- **REFILL**
  - Outputs: `mem_req` = 1, `mem_we` = 0, `mem_addr` = {addr tag, index, 4'b0}.
  - On `mem_ready`: write `mem_rdata` into the line, set the tag, `valid` = 1, `dirty` = 0, and go to IDLE.
  - `cache_busy` = 1.
- The pipeline holds the same request while stalled, so back in IDLE it now hits and completes. Store merging happens only on that hit cycle.

**General rules**
- `mem_ready` is ignored when `mem_req` = 0.
- `addr`, `rd_en`, `wr_en`, `wdata` and `byte_en` must be stable while `cache_busy` = 1. The design relies on this and does not re-check it.
- Misaligned accesses are MEMtop's responsibility. The cache ignores `addr[1:0]` apart from what is already encoded in `byte_en`.

**Reset**
- All `valid` and `dirty` bits clear, state goes to IDLE.
- Outputs: `mem_req` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `rdata` = 0, `cache_busy` = 0.
- Reset during WRITEBACK or REFILL aborts immediately; no line is updated. Data RAM contents need not be cleared.

## Timing
- Hit: zero-cycle latency; `rdata` is valid in the same cycle as `rd_en`.
- When no hit load is in progress, `rdata` = 0.
- Clean miss detected at cycle N:
  - REFILL and `mem_req` start at N+1.
  - With `mem_ready` at cycle M, the line is written at the end of M.
  - The access hits at M+1, with `cache_busy` low.
  - Stall length = M−N+1 cycles.
- Dirty miss: a WRITEBACK phase is inserted before REFILL, with its own `mem_ready` wait. REFILL begins the cycle after the writeback `mem_ready`.
- `mem_ready` in the first cycle of `mem_req` is legal; minimum clean-miss stall = 2 cycles.
- Only one memory transaction is outstanding at a time; `mem_req` drops for at most 0 cycles between WRITEBACK and REFILL.

## Test plan
1. **Clean read miss.** Reset, then `rd_en` at 0x0000_0104 with memory returning `mem_rdata` = {0xDDDD_DDDD, 0xCCCC_CCCC, 0xBBBB_BBBB, 0xAAAA_AAAA} after 3 cycles.
   - `mem_addr` = 0x100, `mem_we` = 0, `cache_busy` high for 4 cycles.
   - Then `rdata` = 0xBBBB_BBBB with `cache_busy` = 0.
2. **Store hit.** `wr_en` at 0x104, `byte_en` = 0100, `wdata` = 0x0055_0000.
   - No `cache_busy`, no `mem_req`.
   - A following read of 0x104 returns 0xBB55_BBBB.
3. **Dirty eviction.** Read 0x1104 (same index 0x10, different tag).
   - WRITEBACK with `mem_addr` = 0x100 and `mem_wdata` word1 = 0xBB55_BBBB.
   - Then REFILL with `mem_addr` = 0x1100.
   - Then a hit.
4. **Clean eviction.** Read 0x2100 after test 3.
   - No WRITEBACK; REFILL straight away with `mem_addr` = 0x2100.
5. **Reset mid-refill.** Assert `rst` while in REFILL.
   - Next cycle `mem_req` = 0 and `cache_busy` = 0.
   - Re-reading 0x104 misses.
6. **Back-to-back mixed traffic.** Hits to different indices on consecutive cycles, plus `rd_en` and `wr_en` asserted together.
   - Zero stall on every access.
   - Simultaneous `rd_en` + `wr_en` behaves as a store.
